pixel_fetch_pipeline: RTL and testbench
=======================================

Name: pixel_fetch_pipeline

Overview:
- Sits directly downstream of the display timing core.
- Consumes its blanking, h_sync, v_sync and linear pixel address.
- Issues reads to a synchronous framebuffer memory, unpacks BPP-bit pixels from memory words, and maps each pixel through a writable palette to RGB.
- Delays the sync and blank signals by the same latency, so the RGB, sync and blank outputs are cycle-aligned for the DAC/encoder.

Parameters:
- A_SIZE, 16, width of incoming pixel address
- BPP, 1, bits per pixel; legal 1, 2, 4, 8
- WORD_W, 8, framebuffer word width; multiple of BPP; PPW = WORD_W/BPP is a power of 2
- MEM_LAT, 1, framebuffer read latency in clocks; legal 1..4
- RGB_W, 12, palette entry / output colour width
- SYNC_IDLE, 1'b1, level driven on h_sync_o/v_sync_o during reset and pipeline fill

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-low reset
- blanking_i  in  1  blanking from timing core
- h_sync_i  in  1  horizontal sync from timing core
- v_sync_i  in  1  vertical sync from timing core
- addr_i  in  A_SIZE  pixel address (0 during blanking)
- mem_en  out  1  framebuffer read enable
- mem_addr  out  A_SIZE-log2(PPW)  framebuffer word address
- mem_data  in  WORD_W  read data, valid MEM_LAT clocks after mem_en
- pal_we  in  1  palette write strobe
- pal_idx  in  BPP  palette entry to write
- pal_data  in  RGB_W  palette write data
- blank_o  out  1  aligned blanking
- h_sync_o  out  1  aligned h_sync
- v_sync_o  out  1  aligned v_sync
- rgb_o  out  RGB_W  pixel colour; 0 while blank_o=1

Behaviour:
- Request stage (combinational):
  - mem_en = ~blanking_i.
  - mem_addr = addr_i >> log2(PPW).
  - sel = addr_i[log2(PPW)-1:0]; zero-width when PPW=1.
- Delay line: a MEM_LAT-deep register chain carries {blanking_i, h_sync_i, v_sync_i, sel}, so it emerges in the same cycle as the matching mem_data.
- Unpack: pixel index = mem_data slice for sel. Pixel 0 occupies the MSBs, i.e. bits [WORD_W-1 -: BPP]; pixel PPW-1 occupies the LSBs.
- Output register (one clock):
  - rgb_o <= delayed_blank ? 0 : palette[index].
  - blank_o, h_sync_o and v_sync_o are the delayed values registered.
- Latency: every input maps to outputs exactly MEM_LAT+1 clocks later. This is fixed and independent of data or palette activity.
- Palette:
  - 2^BPP x RGB_W register file.
  - Write on a rising clk with pal_we=1.
  - A write and a read of the same entry in the same cycle returns the old value; the new value is used from the next cycle.
  - Writes are accepted at any time, including active video; no tearing protection.
- Reset (rst=0, asynchronous):
  - All delay stages: blank=1, syncs=SYNC_IDLE, sel=0.
  - Outputs: blank_o=1, h_sync_o=v_sync_o=SYNC_IDLE, rgb_o=0.
  - Palette: entry 0 = all-zeros; all other entries = all-ones.
- Reset deasserted mid-frame: for MEM_LAT+1 clocks the outputs show the reset (blank) values from the flushed stages, then track the inputs with normal latency. No partial pixel is ever emitted with blank_o=0.
- Address wrap: the word address is a pure truncating shift; A_SIZE wrap from the timing core passes through unchanged.
- mem_data is ignored (masked to rgb_o=0) whenever the delayed blank is 1.

Decomposition:
- Shared package: BPP/PPW legality check, clog2 helper, SEL_W = log2(PPW), palette reset-value constants.
- One natural sub-module: pipe_delay, a parameterised WIDTH x DEPTH register chain with async active-low reset to a RESET_VAL parameter. It is used for the {blank, syncs, sel} bundle.

Test Plan:
- Reset: hold rst=0, toggle inputs -> blank_o=1, h/v_sync_o=1, rgb_o=0; after release with blanking_i=1, outputs stay blanked.
- Latency, default params: active line, addr_i 0..15; memory returns 8'hA5 for word 0 and 8'h3C for word 1 -> mem_addr 0,0,...,1; rgb_o = FFF,000,FFF,000,000,FFF,000,FFF, then 000,000,FFF,FFF,FFF,FFF,000,000, starting 2 clocks after the first active addr.
- Sync alignment, MEM_LAT=3: single-cycle h_sync_i pulse at cycle N -> h_sync_o pulse exactly at cycle N+4; blank_o edges shifted by 4 likewise.
- Palette, BPP=2, WORD_W=8: write idx2=12'h0F0; word 8'b10_01_11_00 -> rgb_o = 0F0, FFF, FFF, 000. A same-cycle write of idx2=12'hF00 during its read shows 0F0 then F00 on the next use.
- Blank masking: blanking_i=1 while memory drives 8'hFF -> mem_en=0, rgb_o=0 throughout.
- Reset mid-line at pixel 7 for 1 cycle -> outputs blanked for MEM_LAT+1 clocks after release; palette restored to defaults (idx1 = FFF).

Source files
------------

// File: rtl/pixel_fetch_pipeline_pkg.sv
// Shared helpers for the pixel fetch pipeline: parameter legality checks,
// unpack geometry and palette reset constants.
package pixel_fetch_pipeline_pkg;

  // Palette reset fill bits: entry 0 resets to black, every other entry to white.
  localparam logic PAL_ENTRY0_FILL = 1'b0;
  localparam logic PAL_OTHER_FILL  = 1'b1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < value) r++;
    end
    return r;
  endfunction

  function automatic bit is_pow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

  function automatic bit geom_legal(input int bpp, input int word_w, input int mem_lat);
    return (bpp == 1 || bpp == 2 || bpp == 4 || bpp == 8) &&
           (word_w % bpp == 0) && is_pow2(word_w / bpp) &&
           (mem_lat >= 1) && (mem_lat <= 4);
  endfunction

  // Number of address LSBs that select a pixel inside one memory word.
  function automatic int sel_w(input int bpp, input int word_w);
    return clog2(word_w / bpp);
  endfunction

endpackage

// File: rtl/pixel_fetch_pipeline_pipe_delay.sv
// Parameterised WIDTH x DEPTH register chain with asynchronous reset to RESET_VAL.
module pipe_delay #(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  // NOTE: non-blocking assignments let every stage sample its predecessor's
  // pre-edge value, so the chain shifts by exactly one stage per clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= RESET_VAL;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/pixel_fetch_pipeline.sv
// Framebuffer fetch, pixel unpack and palette lookup, with sync/blank delayed
// to stay cycle-aligned with the RGB output (fixed latency MEM_LAT+1).
module pixel_fetch_pipeline
  import pixel_fetch_pipeline_pkg::*;
#(
  parameter int   A_SIZE    = 16,
  parameter int   BPP       = 1,
  parameter int   WORD_W    = 8,
  parameter int   MEM_LAT   = 1,
  parameter int   RGB_W     = 12,
  parameter logic SYNC_IDLE = 1'b1
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    blanking_i,
  input  logic                                    h_sync_i,
  input  logic                                    v_sync_i,
  input  logic [A_SIZE-1:0]                       addr_i,
  output logic                                    mem_en,
  output logic [A_SIZE-sel_w(BPP, WORD_W)-1:0]    mem_addr,
  input  logic [WORD_W-1:0]                       mem_data,
  input  logic                                    pal_we,
  input  logic [BPP-1:0]                          pal_idx,
  input  logic [RGB_W-1:0]                        pal_data,
  output logic                                    blank_o,
  output logic                                    h_sync_o,
  output logic                                    v_sync_o,
  output logic [RGB_W-1:0]                        rgb_o
);

  localparam int PPW         = WORD_W / BPP;
  localparam int SEL_W       = sel_w(BPP, WORD_W);
  localparam int SEL_STORE_W = (SEL_W > 0) ? SEL_W : 1;
  localparam int NPAL        = 1 << BPP;

  if (!geom_legal(BPP, WORD_W, MEM_LAT) || (A_SIZE <= SEL_W)) begin : g_bad_params
    $error("pixel_fetch_pipeline: illegal BPP/WORD_W/MEM_LAT/A_SIZE combination");
  end

  typedef struct packed {
    logic                   blank;
    logic                   h_sync;
    logic                   v_sync;
    logic [SEL_STORE_W-1:0] sel;
  } dly_t;

  localparam dly_t DLY_RST = '{blank: 1'b1, h_sync: SYNC_IDLE, v_sync: SYNC_IDLE, sel: '0};

  logic [SEL_STORE_W-1:0] sel;
  dly_t                   dly_in;
  dly_t                   dly_out;
  logic [BPP-1:0]         pix_idx;
  logic [RGB_W-1:0]       pal_q [NPAL];
  logic [RGB_W-1:0]       rgb_d, rgb_q;
  logic                   blank_q, h_sync_q, v_sync_q;

  // Request stage: a pure truncating shift, so timing-core address wrap passes through.
  assign mem_en   = ~blanking_i;
  assign mem_addr = addr_i[A_SIZE-1:SEL_W];

  if (SEL_W > 0) begin : g_sel
    assign sel = addr_i[SEL_W-1:0];
  end else begin : g_no_sel
    assign sel = '0;
  end

  assign dly_in = '{blank: blanking_i, h_sync: h_sync_i, v_sync: v_sync_i, sel: sel};

  pipe_delay #(
    .WIDTH    ($bits(dly_t)),
    .DEPTH    (MEM_LAT),
    .RESET_VAL(DLY_RST)
  ) u_delay (
    .clk  (clk),
    .rst_n(rst),
    .d_i  (dly_in),
    .q_o  (dly_out)
  );

  // NOTE: the palette is reset explicitly because its power-on contents are
  // visible (entry 0 black, the rest white); plain data RAMs are not reset.
  for (genvar g = 0; g < NPAL; g++) begin : g_pal
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        pal_q[g] <= (g == 0) ? {RGB_W{PAL_ENTRY0_FILL}} : {RGB_W{PAL_OTHER_FILL}};
      end else if (pal_we && (pal_idx == BPP'(g))) begin
        pal_q[g] <= pal_data;
      end
    end
  end

  // Pixel 0 sits in the word MSBs, so a higher sel means a smaller right shift.
  // NOTE: every always_comb output gets a value on every path to avoid latches.
  always_comb begin
    pix_idx = BPP'(mem_data >> (BPP * (PPW - 1 - int'(dly_out.sel))));
    rgb_d   = dly_out.blank ? '0 : pal_q[pix_idx];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rgb_q    <= '0;
      blank_q  <= 1'b1;
      h_sync_q <= SYNC_IDLE;
      v_sync_q <= SYNC_IDLE;
    end else begin
      rgb_q    <= rgb_d;
      blank_q  <= dly_out.blank;
      h_sync_q <= dly_out.h_sync;
      v_sync_q <= dly_out.v_sync;
    end
  end

  assign rgb_o    = rgb_q;
  assign blank_o  = blank_q;
  assign h_sync_o = h_sync_q;
  assign v_sync_o = v_sync_q;

endmodule

// File: tb/tb_pixel_fetch_pipeline.sv
// Bench for pixel_fetch_pipeline: two configurations (BPP=1/MEM_LAT=1 and
// BPP=2/MEM_LAT=3) driven together and scored against a per-pixel model.
module tb_pixel_fetch_pipeline;

  localparam int LAT_A = 1;
  localparam int LAT_B = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        blanking = 1'b1, h_sync = 1'b0, v_sync = 1'b0;
  logic [15:0] addr = '0;
  logic        pal_we = 1'b0;
  logic [1:0]  pal_idx = '0;
  logic [11:0] pal_data = '0;

  logic        mem_en_a, blank_a, hs_a, vs_a;
  logic [12:0] mem_addr_a;
  logic [7:0]  mem_data_a;
  logic [11:0] rgb_a;
  logic        mem_en_b, blank_b, hs_b, vs_b;
  logic [13:0] mem_addr_b;
  logic [7:0]  mem_data_b;
  logic [11:0] rgb_b;

  pixel_fetch_pipeline #(.BPP(1), .MEM_LAT(LAT_A)) u_dut_a (
    .clk(clk), .rst(rst), .blanking_i(blanking), .h_sync_i(h_sync), .v_sync_i(v_sync),
    .addr_i(addr), .mem_en(mem_en_a), .mem_addr(mem_addr_a), .mem_data(mem_data_a),
    .pal_we(pal_we), .pal_idx(pal_idx[0]), .pal_data(pal_data),
    .blank_o(blank_a), .h_sync_o(hs_a), .v_sync_o(vs_a), .rgb_o(rgb_a));

  pixel_fetch_pipeline #(.BPP(2), .MEM_LAT(LAT_B)) u_dut_b (
    .clk(clk), .rst(rst), .blanking_i(blanking), .h_sync_i(h_sync), .v_sync_i(v_sync),
    .addr_i(addr), .mem_en(mem_en_b), .mem_addr(mem_addr_b), .mem_data(mem_data_b),
    .pal_we(pal_we), .pal_idx(pal_idx), .pal_data(pal_data),
    .blank_o(blank_b), .h_sync_o(hs_b), .v_sync_o(vs_b), .rgb_o(rgb_b));

  // Framebuffer: synchronous reads, MEM_LAT clocks; idle bus floats to all-ones.
  logic [7:0] fb [256];
  logic       ra_en = 1'b0;
  logic [7:0] ra_word = '0;
  logic       rb_en [LAT_B];
  logic [7:0] rb_word [LAT_B];

  always @(posedge clk) begin
    ra_en   <= mem_en_a;
    ra_word <= mem_addr_a[7:0];
    rb_en[0]   <= mem_en_b;
    rb_word[0] <= mem_addr_b[7:0];
    for (int i = 1; i < LAT_B; i++) begin
      rb_en[i]   <= rb_en[i-1];
      rb_word[i] <= rb_word[i-1];
    end
  end

  assign mem_data_a = ra_en ? fb[ra_word] : 8'hFF;
  assign mem_data_b = rb_en[LAT_B-1] ? fb[rb_word[LAT_B-1]] : 8'hFF;

  // Reference model: one entry per input cycle, resolved to a colour when the
  // pipeline reaches its palette lookup.
  typedef struct { bit blank; bit hs; bit vs; logic [15:0] addr; } ent_t;
  typedef struct { bit blank; bit hs; bit vs; logic [11:0] rgb; } exp_t;

  ent_t        hist_a[$], hist_b[$];
  exp_t        exp_a[$], exp_b[$];
  logic [11:0] pal_a [2];
  logic [11:0] pal_b [4];
  int          n_cmp = 0, n_bad = 0;

  logic        obs_blank_a, obs_blank_b, obs_hs_a, obs_hs_b;
  logic [11:0] obs_rgb_a, obs_rgb_b;

  function automatic logic [11:0] ref_rgb_a(input ent_t e);
    logic [7:0] word;
    int         bitpos;
    if (e.blank) return 12'h000;
    word   = fb[(e.addr / 8) % 256];
    bitpos = 7 - int'(e.addr % 8);
    return pal_a[word[bitpos]];
  endfunction

  function automatic logic [11:0] ref_rgb_b(input ent_t e);
    logic [7:0] word;
    int         pix;
    if (e.blank) return 12'h000;
    word = fb[(e.addr / 4) % 256];
    pix  = (int'(word) >> (2 * (3 - int'(e.addr % 4)))) % 4;
    return pal_b[pix];
  endfunction

  task automatic model_reset();
    ent_t rst_ent;
    exp_t rst_exp;
    rst_ent = '{1'b1, 1'b1, 1'b1, 16'h0};
    rst_exp = '{1'b1, 1'b1, 1'b1, 12'h000};
    hist_a.delete(); hist_b.delete(); exp_a.delete(); exp_b.delete();
    for (int i = 0; i < LAT_A; i++) hist_a.push_back(rst_ent);
    for (int i = 0; i < LAT_B; i++) hist_b.push_back(rst_ent);
    exp_a.push_back(rst_exp);
    exp_b.push_back(rst_exp);
    pal_a = '{12'h000, 12'hFFF};
    pal_b = '{12'h000, 12'hFFF, 12'hFFF, 12'hFFF};
  endtask

  // One pixel clock: score current outputs, drive new inputs, advance the model.
  task automatic step(input bit bl, input bit hs, input bit vs, input logic [15:0] ad,
                      input bit we, input logic [1:0] idx, input logic [11:0] dat);
    exp_t ea, eb, xa, xb;
    ent_t e, oa, ob;
    obs_blank_a = blank_a; obs_hs_a = hs_a; obs_rgb_a = rgb_a;
    obs_blank_b = blank_b; obs_hs_b = hs_b; obs_rgb_b = rgb_b;
    n_cmp += 2;
    if (exp_a.size() == 0 || exp_b.size() == 0) begin
      n_bad++;
      $display("FAIL model_underflow: expectation queue empty at %0t", $time);
    end else begin
      ea = exp_a.pop_front();
      eb = exp_b.pop_front();
      if ({blank_a, hs_a, vs_a, rgb_a} !== {ea.blank, ea.hs, ea.vs, ea.rgb}) begin
        n_bad++;
        $display("FAIL out_a @%0t: got blank=%b hs=%b vs=%b rgb=%h, want blank=%b hs=%b vs=%b rgb=%h",
                 $time, blank_a, hs_a, vs_a, rgb_a, ea.blank, ea.hs, ea.vs, ea.rgb);
      end
      if ({blank_b, hs_b, vs_b, rgb_b} !== {eb.blank, eb.hs, eb.vs, eb.rgb}) begin
        n_bad++;
        $display("FAIL out_b @%0t: got blank=%b hs=%b vs=%b rgb=%h, want blank=%b hs=%b vs=%b rgb=%h",
                 $time, blank_b, hs_b, vs_b, rgb_b, eb.blank, eb.hs, eb.vs, eb.rgb);
      end
    end
    blanking = bl; h_sync = hs; v_sync = vs; addr = ad;
    pal_we = we; pal_idx = idx; pal_data = dat;
    #1;
    n_cmp += 2;
    if ({mem_en_a, mem_addr_a} !== {~bl, 13'(ad / 8)}) begin
      n_bad++;
      $display("FAIL req_a @%0t: got en=%b addr=%h, want en=%b addr=%h",
               $time, mem_en_a, mem_addr_a, ~bl, 13'(ad / 8));
    end
    if ({mem_en_b, mem_addr_b} !== {~bl, 14'(ad / 4)}) begin
      n_bad++;
      $display("FAIL req_b @%0t: got en=%b addr=%h, want en=%b addr=%h",
               $time, mem_en_b, mem_addr_b, ~bl, 14'(ad / 4));
    end
    e = '{bl, hs, vs, ad};
    hist_a.push_back(e);
    hist_b.push_back(e);
    oa = hist_a.pop_front();
    ob = hist_b.pop_front();
    xa = '{oa.blank, oa.hs, oa.vs, ref_rgb_a(oa)};
    xb = '{ob.blank, ob.hs, ob.vs, ref_rgb_b(ob)};
    exp_a.push_back(xa);
    exp_b.push_back(xb);
    if (we) begin
      pal_a[idx[0]] = dat;
      pal_b[idx]    = dat;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 2'd0, 12'h0);
  endtask

  task automatic check_reset_outputs(input string tag);
    n_cmp += 1;
    if ({blank_a, hs_a, vs_a, rgb_a, blank_b, hs_b, vs_b, rgb_b} !==
        {1'b1, 1'b1, 1'b1, 12'h000, 1'b1, 1'b1, 1'b1, 12'h000}) begin
      n_bad++;
      $display("FAIL %s: got a=%b%b%b/%h b=%b%b%b/%h, want 111/000 on both",
               tag, blank_a, hs_a, vs_a, rgb_a, blank_b, hs_b, vs_b, rgb_b);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      blanking = i[0]; h_sync = ~i[0]; v_sync = i[1]; addr = 16'(i * 3);
      pal_we = 1'b1; pal_idx = 2'(i); pal_data = 12'h123;
      #1;
      check_reset_outputs("reset_hold");
      @(negedge clk);
    end
    pal_we = 1'b0; blanking = 1'b1;
    model_reset();
    rst = 1'b1;
    idle(6);
  endtask

  task automatic test_latency_default();
    logic [11:0] tbl [16] = '{12'hFFF, 12'h000, 12'hFFF, 12'h000, 12'h000, 12'hFFF, 12'h000, 12'hFFF,
                              12'h000, 12'h000, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'h000, 12'h000};
    fb[0] = 8'hA5; fb[1] = 8'h3C; fb[2] = 8'h00; fb[3] = 8'h00;
    for (int i = 0; i < 22; i++) begin
      if (i < 16) step(1'b0, 1'b0, 1'b0, 16'(i), 1'b0, 2'd0, 12'h0);
      else        step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 2'd0, 12'h0);
      if (i >= 2 && i < 18) begin
        n_cmp++;
        if (obs_rgb_a !== tbl[i-2]) begin
          n_bad++;
          $display("FAIL latency_pixel%0d: got rgb=%h, want %h", i - 2, obs_rgb_a, tbl[i-2]);
        end
      end
    end
  endtask

  task automatic test_sync_alignment();
    for (int i = 0; i < 12; i++) begin
      step(i < 3, i == 2, 1'b0, (i < 3) ? 16'h0 : 16'(i), 1'b0, 2'd0, 12'h0);
      n_cmp += 2;
      if ({obs_hs_b, obs_blank_b} !== {i == 6, i < 7}) begin
        n_bad++;
        $display("FAIL sync_align_b step%0d: got hs=%b blank=%b, want hs=%b blank=%b",
                 i, obs_hs_b, obs_blank_b, i == 6, i < 7);
      end
      if ({obs_hs_a, obs_blank_a} !== {i == 4, i < 5}) begin
        n_bad++;
        $display("FAIL sync_align_a step%0d: got hs=%b blank=%b, want hs=%b blank=%b",
                 i, obs_hs_a, obs_blank_a, i == 4, i < 5);
      end
    end
    idle(5);
  endtask

  task automatic test_palette();
    logic [15:0] seq [6] = '{16'd16, 16'd17, 16'd18, 16'd19, 16'd16, 16'd17};
    logic [11:0] want [6] = '{12'h0F0, 12'hFFF, 12'hFFF, 12'h000, 12'hF00, 12'hFFF};
    fb[4] = 8'b10_01_11_00;
    for (int i = 0; i < 12; i++) begin
      if (i == 0)     step(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 2'd2, 12'h0F0);
      else if (i < 7) step(1'b0, 1'b0, 1'b0, seq[i-1], i == 4, 2'd2, 12'hF00);
      else            step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 2'd0, 12'h0);
      if (i >= 5 && i <= 10) begin
        n_cmp++;
        if (obs_rgb_b !== want[i-5]) begin
          n_bad++;
          $display("FAIL palette_b use%0d: got rgb=%h, want %h", i - 5, obs_rgb_b, want[i-5]);
        end
      end
    end
  endtask

  task automatic test_blank_masking();
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 2'd0, 12'h0);
      if (i >= 4) begin
        n_cmp++;
        if ({obs_rgb_a, obs_rgb_b} !== 24'h0) begin
          n_bad++;
          $display("FAIL blank_mask step%0d: got rgb_a=%h rgb_b=%h, want 000",
                   i, obs_rgb_a, obs_rgb_b);
        end
      end
    end
  endtask

  task automatic test_random();
    bit bl;
    for (int i = 0; i < 256; i++) fb[i] = 8'($urandom);
    for (int i = 0; i < 600; i++) begin
      bl = ($urandom_range(0, 3) == 0);
      step(bl, $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
           bl ? 16'h0 : 16'($urandom), $urandom_range(0, 9) == 0,
           2'($urandom), 12'($urandom));
    end
    idle(5);
  endtask

  task automatic test_reset_midline();
    logic [11:0] tbl [8] = '{12'h000, 12'h000, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'h000, 12'h000};
    fb[0] = 8'hA5; fb[1] = 8'h3C; fb[2] = 8'h00; fb[3] = 8'h00;
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 16'(i), 1'b0, 2'd0, 12'h0);
    rst = 1'b0; pal_we = 1'b0;
    #1;
    check_reset_outputs("reset_async");
    @(negedge clk);
    check_reset_outputs("reset_midline");
    model_reset();
    rst = 1'b1;
    for (int k = 0; k < 14; k++) begin
      if (k < 8) step(1'b0, 1'b0, 1'b0, 16'(8 + k), 1'b0, 2'd0, 12'h0);
      else       step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 2'd0, 12'h0);
      if (k < 10) begin
        n_cmp += 2;
        if ({obs_blank_a, obs_blank_b} !== {k < 2, k < 4}) begin
          n_bad++;
          $display("FAIL reset_flush step%0d: got blank_a=%b blank_b=%b, want %b %b",
                   k, obs_blank_a, obs_blank_b, k < 2, k < 4);
        end
        if (k >= 2 && obs_rgb_a !== tbl[k-2]) begin
          n_bad++;
          $display("FAIL reset_palette pixel%0d: got rgb=%h, want %h", 8 + k - 2, obs_rgb_a, tbl[k-2]);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) fb[i] = 8'h00;
    for (int i = 0; i < LAT_B; i++) begin
      rb_en[i]   = 1'b0;
      rb_word[i] = '0;
    end
    test_reset();
    test_latency_default();
    test_sync_alignment();
    test_palette();
    test_blank_masking();
    test_random();
    test_reset_midline();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
